// File: rtl/gpu_mem_pkg.sv
// Types and constants shared by the GPU memory interconnect and its slave endpoints.
package gpu_mem_pkg;

  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned BE_W                = DATA_W / 8;
  localparam int unsigned DEFAULT_WINDOW_BITS = 14;
  // The interconnect selects a slave with the first address bit above the window.
  localparam int unsigned SLAVE_SEL_BIT       = DEFAULT_WINDOW_BITS;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } mem_resp_t;

  typedef enum logic {CLEAR, RUN} responder_state_e;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_word,
                                                 input logic [DATA_W-1:0] new_word,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/resp_pipe.sv
// Fixed-latency shift register carrying a valid bit plus response payload.
// Synchronous flush drops everything in flight; payload itself is not reset.
module resp_pipe
  import gpu_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic      clk,
  input  logic      i_flush,
  input  logic      i_valid,
  input  mem_resp_t i_resp,
  output logic      o_valid,
  output mem_resp_t o_resp
);

  logic [LATENCY-1:0] r_valid;
  mem_resp_t          r_resp [LATENCY];

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_resp[0] <= i_resp;
    for (int i = 1; i < int'(LATENCY); i++) begin
      r_resp[i] <= r_resp[i-1];
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_resp  = r_resp[LATENCY-1];

endmodule

// File: rtl/slave_mem_responder.sv
// Slave endpoint owning one memory window: clears its RAM after reset, then answers
// every accepted read/write with one in-order response after LATENCY cycles.
module slave_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WINDOW_BITS    = 14,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  output logic                    o_ready,
  output logic                    o_resp_valid,
  output logic                    o_resp_we,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_err
);

  localparam int unsigned IDX_W  = WINDOW_BITS - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  responder_state_e      r_state;
  logic                  r_ready;
  logic [MEM_AW-1:0]     r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [IDX_W-1:0]      w_idx;
  logic [MEM_AW-1:0]     w_midx;
  logic                  w_err;
  logic                  w_accept;
  mem_resp_t             w_resp_in;
  mem_resp_t             w_pipe_resp;
  logic                  w_pipe_valid;
  logic                  w_pipe_rd;
  logic                  w_unused_addr;

  assign w_idx         = i_addr[WINDOW_BITS-1:2];
  assign w_midx        = w_idx[MEM_AW-1:0];
  assign w_err         = (i_addr[1:0] != 2'b00) || (32'(w_idx) >= DEPTH);
  assign w_accept      = i_req && r_ready && !rst;
  assign w_unused_addr = ^i_addr[ADDR_WIDTH-1:WINDOW_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      r_ready   <= (CLEAR_ON_RESET == 0);
      r_clr_cnt <= '0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == MEM_AW'(DEPTH - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: r_ready <= 1'b1;
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Reads use the pre-edge array contents, so a same-word write is seen one cycle later.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_accept && i_we && !w_err) begin
      r_mem[w_midx] <= be_merge(r_mem[w_midx], i_wdata, i_be);
    end
  end

  always_comb begin
    w_resp_in     = '0;
    w_resp_in.we  = i_we;
    w_resp_in.err = w_err;
    if (!i_we && !w_err) w_resp_in.rdata = r_mem[w_midx];
  end

  resp_pipe #(
    .LATENCY(LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .i_flush(rst),
    .i_valid(w_accept),
    .i_resp (w_resp_in),
    .o_valid(w_pipe_valid),
    .o_resp (w_pipe_resp)
  );

  assign w_pipe_rd = w_pipe_valid && !w_pipe_resp.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_pipe_rd) begin
      r_rdata <= w_pipe_resp.rdata;
    end
  end

  assign o_ready      = r_ready;
  assign o_resp_valid = w_pipe_valid;
  assign o_resp_we    = w_pipe_valid && w_pipe_resp.we;
  assign o_err        = w_pipe_valid && w_pipe_resp.err;
  assign o_rdata      = w_pipe_rd ? w_pipe_resp.rdata : r_rdata;

endmodule
